pipe_path: RTL and testbench

Parametrised, pipelined successor to the single-cycle add datapath. It is a four-stage in-order integer core slice: F (fetch), D (decode / register read), E (execute), W (writeback). It has an internal 64-entry register file, full forwarding, a stall input, a HALT instruction and a retired-instruction counter. It sits between a synchronous instruction memory and the top-level test harness, which monitors the writeback and status outputs.

---
 rtl/pipe_path.sv | 130 +++++++++++++
 tb/tb_pipe_path.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_path.sv
// Four-stage (F/D/E/W) in-order integer slice: 64-entry regfile, full
// forwarding resolved in D, stall freeze, sticky HALT and a retired counter.
module pipe_path #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 14,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             wb_valid,
  output logic [5:0]       wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam int SHW    = $clog2(XLEN);
  localparam int STAGES = 2;

  typedef struct packed {
    logic            alu;
    logic            halt;
    logic [2:0]      op;
    logic [5:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } ex_t;

  typedef struct packed {
    logic            alu;
    logic            halt;
    logic [5:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  // vld_pipe[0]=D, [1]=E, [2]=W
  logic [STAGES:0] vld_pipe;
  logic            fe_en;
  ex_t             ex;
  wb_t             wb;
  logic [XLEN-1:0] rf [64];

  logic [2:0]      d_op, d_cls;
  logic [5:0]      d_rd, d_rs1, d_rs2;
  logic [7:0]      d_imm;
  logic            halt_d, e_fwd, w_fwd;
  logic [XLEN-1:0] src_a, src_b, imm_sx, e_res;

  // D decodes the memory word directly; the memory holds it across stalls.
  assign d_op   = imem_rdata[2:0];
  assign d_cls  = imem_rdata[5:3];
  assign d_rd   = imem_rdata[11:6];
  assign d_rs1  = imem_rdata[17:12];
  assign d_rs2  = imem_rdata[23:18];
  assign d_imm  = imem_rdata[31:24];
  assign imm_sx = {{(XLEN-8){d_imm[7]}}, d_imm};

  assign halt_d = vld_pipe[0] && (d_cls == 3'b111);
  assign e_fwd  = vld_pipe[1] && ex.alu && (ex.rd != 6'd0);
  assign w_fwd  = vld_pipe[2] && wb.alu && (wb.rd != 6'd0);

  always_comb begin
    src_a = '0;
    src_b = '0;
    if (d_rs1 == 6'd0)                 src_a = '0;
    else if (e_fwd && ex.rd == d_rs1)  src_a = e_res;
    else if (w_fwd && wb.rd == d_rs1)  src_a = wb.data;
    else                               src_a = rf[d_rs1];
    if (d_rs2 == 6'd0)                 src_b = '0;
    else if (e_fwd && ex.rd == d_rs2)  src_b = e_res;
    else if (w_fwd && wb.rd == d_rs2)  src_b = wb.data;
    else                               src_b = rf[d_rs2];
  end

  // ADDI shares the adder with ADD; its immediate is substituted for rs2 in D.
  always_comb begin
    e_res = '0;
    case (ex.op)
      3'd0, 3'd7: e_res = ex.a + ex.b;
      3'd1:       e_res = ex.a - ex.b;
      3'd2:       e_res = ex.a & ex.b;
      3'd3:       e_res = ex.a | ex.b;
      3'd4:       e_res = ex.a ^ ex.b;
      3'd5:       e_res = {{(XLEN-1){1'b0}}, ($signed(ex.a) < $signed(ex.b))};
      3'd6:       e_res = ex.a << ex.b[SHW-1:0];
      default:    e_res = '0;
    endcase
  end

  assign imem_en   = fe_en && !stall && !rst;
  assign imem_addr = pc;
  assign wb_valid  = w_fwd && !stall && !rst;
  assign wb_addr   = wb.rd;
  assign wb_data   = wb.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      fe_en    <= 1'b1;
      vld_pipe <= '0;
      ex       <= '0;
      wb       <= '0;
      halted   <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < 64; i++) rf[i] <= '0;
    end else if (!stall) begin
      if (fe_en && !halt_d) pc <= pc + PC_W'(4);
      if (halt_d) fe_en <= 1'b0;
      // the word fetched alongside a HALT in D is squashed here
      vld_pipe <= {vld_pipe[1], vld_pipe[0], fe_en && !halt_d};
      ex.alu   <= (d_cls == 3'b000);
      ex.halt  <= (d_cls == 3'b111);
      ex.op    <= d_op;
      ex.rd    <= d_rd;
      ex.a     <= src_a;
      ex.b     <= (d_op == 3'd7) ? imm_sx : src_b;
      wb.alu   <= ex.alu;
      wb.halt  <= ex.halt;
      wb.rd    <= ex.rd;
      wb.data  <= e_res;
      if (wb_valid) rf[wb.rd] <= wb.data;
      if (vld_pipe[2] && !wb.halt) retired <= retired + CNT_W'(1);
      if (vld_pipe[2] && wb.halt)  halted  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_path.sv
// Bench for pipe_path: program tables with a writeback scoreboard (register,
// value and exact cycle), plus stall, HALT and reset sequences.
module tb_pipe_path;
  localparam int XLEN = 64, PC_W = 14, CNT_W = 32;
  localparam logic [31:0] NOP  = 32'h0000_0008;
  localparam logic [31:0] HALT = 32'h0000_0038;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic             imem_en;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_rdata = NOP;
  logic             wb_valid;
  logic [5:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic [CNT_W-1:0] retired;

  pipe_path #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory, holds its output while imem_en=0
  logic [31:0] prog [256];
  always @(posedge clk) if (imem_en) imem_rdata <= prog[imem_addr[9:2]];

  int cyc = 0, base = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] ins;
    logic        wr;
    logic [5:0]  rd;
    logic [63:0] data;
  } vec_t;
  typedef struct {
    logic [5:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [5:0] rd,
                                      input logic [5:0] rs1, input logic [5:0] rs2,
                                      input logic [7:0] imm);
    return {imm, rs2, rs1, rd, 3'b000, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  task automatic set_v(input int i, input logic [31:0] ins, input logic wr,
                       input logic [5:0] rd, input logic [63:0] d);
    tbl[i] = '{ins, wr, rd, d};
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = NOP;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one-cycle reset, after which cycle k=0 is the first fetch cycle
  task automatic pulse_reset();
    rst = 1'b1; stall = 1'b0;
    step();
    rst = 1'b0;
    base = cyc;
  endtask

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got x%0d=%0h at cycle %0d, required no write",
                 wb_addr, wb_data, cyc - base);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_addr !== e.rd || wb_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL wb: got x%0d=%0h at cycle %0d, required x%0d=%0h at cycle %0d",
                   wb_addr, wb_data, cyc - base, e.rd, e.data, e.cyc - base);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values, then NOP stream fetch sequencing ----
    clear_prog();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_imem_en", 64'(imem_en), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    step();
    rst = 1'b0;
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("fetch_en", 64'(imem_en), 64'd1);
        chk("fetch_addr", 64'(imem_addr), 64'(4 * k));
      end
      chk("retired_ramp", 64'(retired), 64'(k < 4 ? 0 : k - 3));
      chk("nop_halted", 64'(halted), 64'd0);
      step();
    end

    // ---- program A: dependency chain, ALU coverage, x0, HALT ----
    set_v(0,  enc(3'd7, 6'd1,  6'd0, 6'd0, 8'd5),    1, 6'd1,  64'd5);
    set_v(1,  enc(3'd7, 6'd2,  6'd1, 6'd0, 8'd3),    1, 6'd2,  64'd8);
    set_v(2,  enc(3'd0, 6'd3,  6'd1, 6'd2, 8'd0),    1, 6'd3,  64'd13);
    set_v(3,  enc(3'd7, 6'd1,  6'd0, 6'd0, 8'hFF),   1, 6'd1,  ONES);
    set_v(4,  enc(3'd5, 6'd4,  6'd1, 6'd0, 8'd0),    1, 6'd4,  64'd1);
    set_v(5,  enc(3'd7, 6'd5,  6'd0, 6'd0, 8'd63),   1, 6'd5,  64'd63);
    set_v(6,  enc(3'd7, 6'd6,  6'd0, 6'd0, 8'd1),    1, 6'd6,  64'd1);
    set_v(7,  enc(3'd6, 6'd7,  6'd6, 6'd5, 8'd0),    1, 6'd7,  64'h8000_0000_0000_0000);
    set_v(8,  enc(3'd4, 6'd8,  6'd1, 6'd1, 8'd0),    1, 6'd8,  64'd0);
    set_v(9,  enc(3'd1, 6'd9,  6'd0, 6'd6, 8'd0),    1, 6'd9,  ONES);
    set_v(10, enc(3'd7, 6'd0,  6'd0, 6'd0, 8'd7),    0, 6'd0,  64'd0);
    set_v(11, enc(3'd0, 6'd10, 6'd0, 6'd0, 8'd0),    1, 6'd10, 64'd0);
    set_v(12, enc(3'd3, 6'd11, 6'd3, 6'd2, 8'd0),    1, 6'd11, 64'd13);
    set_v(13, enc(3'd2, 6'd12, 6'd3, 6'd2, 8'd0),    1, 6'd12, 64'd8);
    set_v(14, enc(3'd5, 6'd13, 6'd6, 6'd5, 8'd0),    1, 6'd13, 64'd1);
    set_v(15, enc(3'd7, 6'd15, 6'd9, 6'd0, 8'd2),    1, 6'd15, 64'd1);
    set_v(16, enc(3'd5, 6'd16, 6'd5, 6'd6, 8'd0),    1, 6'd16, 64'd0);
    set_v(17, enc(3'd1, 6'd17, 6'd5, 6'd6, 8'd0),    1, 6'd17, 64'd62);
    set_v(18, HALT,                                   0, 6'd0,  64'd0);
    set_v(19, enc(3'd7, 6'd11, 6'd0, 6'd0, 8'd1),    0, 6'd0,  64'd0);
    clear_prog();
    for (int i = 0; i < 20; i++) prog[i] = tbl[i].ins;
    pulse_reset();
    for (int i = 0; i < 20; i++)
      if (tbl[i].wr) sb.push_back('{rd: tbl[i].rd, data: tbl[i].data, cyc: base + i + 3});
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 19) begin
        chk("a_halt_d_pc", 64'(pc), 64'd76);
        chk("a_halt_d_en", 64'(imem_en), 64'd1);
      end
      if (k == 20) chk("a_halt_en_off", 64'(imem_en), 64'd0);
      if (k == 21) chk("a_halted_early", 64'(halted), 64'd0);
      if (k == 22) chk("a_halted_rise", 64'(halted), 64'd1);
      if (k == 30) begin
        chk("a_pc_hold", 64'(pc), 64'd76);
        chk("a_en_hold", 64'(imem_en), 64'd0);
        chk("a_halted_hold", 64'(halted), 64'd1);
        chk("a_retired", 64'(retired), 64'd18);
      end
      step();
    end
    chk("a_sb_empty", 64'(sb.size()), 64'd0);

    // ---- program B: 3-cycle stall with chain in D/E/W ----
    clear_prog();
    prog[0] = enc(3'd7, 6'd1, 6'd0, 6'd0, 8'd5);
    prog[1] = enc(3'd7, 6'd2, 6'd1, 6'd0, 8'd3);
    prog[2] = enc(3'd0, 6'd3, 6'd1, 6'd2, 8'd0);
    prog[6] = HALT;
    pulse_reset();
    sb.push_back('{rd: 6'd1, data: 64'd5,  cyc: base + 6});
    sb.push_back('{rd: 6'd2, data: 64'd8,  cyc: base + 7});
    sb.push_back('{rd: 6'd3, data: 64'd13, cyc: base + 8});
    for (int k = 0; k <= 20; k++) begin
      stall = (k >= 3 && k <= 5);
      @(negedge clk);
      if (k >= 3 && k <= 6) chk("b_retired_frozen", 64'(retired), 64'd0);
      if (k == 7)  chk("b_retired_resume", 64'(retired), 64'd1);
      if (k == 4)  chk("b_stall_en", 64'(imem_en), 64'd0);
      if (k == 6) begin
        chk("b_resume_addr", 64'(imem_addr), 64'd12);
        chk("b_resume_en", 64'(imem_en), 64'd1);
      end
      if (k == 12) chk("b_halted_early", 64'(halted), 64'd0);
      if (k == 13) chk("b_halted_rise", 64'(halted), 64'd1);
      if (k == 20) begin
        chk("b_pc", 64'(pc), 64'd28);
        chk("b_retired", 64'(retired), 64'd6);
      end
      step();
    end
    stall = 1'b0;
    chk("b_sb_empty", 64'(sb.size()), 64'd0);

    // ---- program C: stall while HALT sits in D ----
    clear_prog();
    prog[0] = enc(3'd7, 6'd20, 6'd0, 6'd0, 8'd9);
    prog[1] = HALT;
    prog[2] = enc(3'd7, 6'd21, 6'd0, 6'd0, 8'd1);
    pulse_reset();
    sb.push_back('{rd: 6'd20, data: 64'd9, cyc: base + 5});
    for (int k = 0; k <= 10; k++) begin
      stall = (k == 2 || k == 3);
      @(negedge clk);
      if (k == 2) chk("c_stall_en", 64'(imem_en), 64'd0);
      if (k == 4) begin
        chk("c_halt_en", 64'(imem_en), 64'd1);
        chk("c_halt_pc", 64'(pc), 64'd8);
      end
      if (k == 5)  chk("c_en_off", 64'(imem_en), 64'd0);
      if (k == 6)  chk("c_halted_early", 64'(halted), 64'd0);
      if (k == 7)  chk("c_halted_rise", 64'(halted), 64'd1);
      if (k == 10) begin
        chk("c_pc", 64'(pc), 64'd8);
        chk("c_retired", 64'(retired), 64'd1);
      end
      step();
    end
    stall = 1'b0;
    chk("c_sb_empty", 64'(sb.size()), 64'd0);

    // ---- program D: reset out of halt clears state, fetch restarts ----
    clear_prog();
    prog[0] = enc(3'd0, 6'd22, 6'd20, 6'd0, 8'd0);
    prog[1] = HALT;
    pulse_reset();
    sb.push_back('{rd: 6'd22, data: 64'd0, cyc: base + 3});
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("d_halted_clr", 64'(halted), 64'd0);
        chk("d_pc_zero", 64'(pc), 64'd0);
        chk("d_en", 64'(imem_en), 64'd1);
        chk("d_addr0", 64'(imem_addr), 64'd0);
      end
      if (k == 1) chk("d_addr4", 64'(imem_addr), 64'd4);
      if (k == 10) begin
        chk("d_retired", 64'(retired), 64'd1);
        chk("d_halted", 64'(halted), 64'd1);
        chk("d_pc", 64'(pc), 64'd8);
      end
      step();
    end
    chk("d_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
